// File: rtl/ula_pkg.sv
// ula_pkg: shared sizes, opcodes and FSM encoding for the 5x5 matrix ALU.
package ula_pkg;
    localparam int N = 5;
    localparam int W = 9;
    localparam int MATW = N * N * W;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_TRANSP = 3'b011;
    localparam logic [2:0] OP_NEG = 3'b100;
    typedef enum logic [1:0] {IDLE, ELEM, MAC, FIM} state_t;
    function automatic logic signed [W-1:0] elt(input logic [MATW-1:0] m, input int i);
        return m[i*W +: W];
    endfunction
    function automatic logic reserved_op(input logic [2:0] o);
        return o > OP_NEG;
    endfunction
endpackage

// File: rtl/ula_elem_sat.sv
// ula_elem_sat: clamps a 21-bit signed value to the 9-bit element range.
module ula_elem_sat
    import ula_pkg::*;
(
    input  logic signed [20:0]  val,
    output logic signed [W-1:0] res,
    output logic                sat
);
    always_comb begin
        sat = val > 21'sd255 || val < -21'sd256;
        res = val > 21'sd255 ? 9'h0ff : val < -21'sd256 ? 9'h100 : val[W-1:0];
    end
endmodule

// File: rtl/ula_matricial.sv
// ula_matricial: sequential 5x5 matrix ALU (add/sub/mul/transpose/negate).
// One element per cycle for element-wise ops, one MAC per cycle for MUL.
module ula_matricial
    import ula_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      operacao,
    input  logic [MATW-1:0] matriz_A,
    input  logic [MATW-1:0] matriz_B,
    output logic [MATW-1:0] matriz_resultado,
    output logic            done,
    output logic            busy,
    output logic            overflow,
    output logic            erro
);
    state_t state, state_n;
    logic [2:0] op;
    logic [MATW-1:0] a, b;
    logic [4:0] k;
    logic [2:0] s;
    logic signed [20:0] acc, acc_n, prod, sat_in;
    logic signed [9:0] sum;
    logic signed [W-1:0] sat_out;
    logic sat, accept;
    int r, c;

    assign accept = state == IDLE && start && !busy;

    always_comb begin
        r = int'(k) / N;
        c = int'(k) % N;
        prod = 21'(elt(a, r * N + int'(s))) * 21'(elt(b, int'(s) * N + c));
        acc_n = (s == 3'd0 ? 21'sd0 : acc) + prod;
        sum = op == OP_SUB ? 10'(elt(a, r * N + c)) - 10'(elt(b, r * N + c)) :
              op == OP_NEG ? -10'(elt(a, r * N + c)) :
                             10'(elt(a, r * N + c)) + 10'(elt(b, r * N + c));
        sat_in = state == MAC ? acc_n : op == OP_TRANSP ? 21'(elt(a, c * N + r)) : 21'(sum);
    end

    ula_elem_sat u_sat (.val(sat_in), .res(sat_out), .sat(sat));

    // Reserved ops spend two cycles in FIM: first clears the result, second pulses done.
    always_comb begin
        state_n = state;
        case (state)
            IDLE: if (accept) state_n = operacao == OP_MUL ? MAC : reserved_op(operacao) ? FIM : ELEM;
            ELEM: if (k == 5'd24) state_n = FIM;
            MAC: if (k == 5'd24 && s == 3'd4) state_n = FIM;
            default: if (!(reserved_op(op) && !erro)) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    // busy drops one cycle after done so a start coinciding with done is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op <= '0;
            a <= '0;
            b <= '0;
            k <= '0;
            s <= '0;
            acc <= '0;
            matriz_resultado <= '0;
            done <= 1'b0;
            busy <= 1'b0;
            overflow <= 1'b0;
            erro <= 1'b0;
        end else begin
            done <= 1'b0;
            if (done) busy <= 1'b0;
            case (state)
                IDLE: if (accept) begin
                    op <= operacao;
                    a <= matriz_A;
                    b <= matriz_B;
                    overflow <= 1'b0;
                    erro <= 1'b0;
                    busy <= 1'b1;
                    k <= '0;
                    s <= '0;
                    acc <= '0;
                end
                ELEM: begin
                    matriz_resultado[int'(k)*W +: W] <= sat_out;
                    overflow <= overflow | sat;
                    k <= k + 5'd1;
                end
                MAC: begin
                    acc <= acc_n;
                    s <= s == 3'd4 ? 3'd0 : s + 3'd1;
                    if (s == 3'd4) begin
                        matriz_resultado[int'(k)*W +: W] <= sat_out;
                        overflow <= overflow | sat;
                        k <= k + 5'd1;
                    end
                end
                default: if (reserved_op(op) && !erro) begin
                    erro <= 1'b1;
                    matriz_resultado <= '0;
                end else done <= 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_matricial.sv
// tb_ula_matricial: directed scoreboard bench for the 5x5 matrix ALU.
module tb_ula_matricial;
    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [2:0] operacao = '0;
    logic [224:0] matriz_A = '0, matriz_B = '0, matriz_resultado;
    logic done, busy, overflow, erro;
    int cyc = 0, passed = 0, total = 0;

    typedef struct {
        logic [224:0] m;
        logic ov;
        logic er;
        int lat;
    } exp_t;
    exp_t sb[$];

    ula_matricial dut (
        .clk(clk), .rst(rst), .start(start), .operacao(operacao),
        .matriz_A(matriz_A), .matriz_B(matriz_B), .matriz_resultado(matriz_resultado),
        .done(done), .busy(busy), .overflow(overflow), .erro(erro)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [224:0] got, input logic [224:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [224:0] fill(input int v);
        logic [224:0] m;
        for (int i = 0; i < 25; i++) m[i*9 +: 9] = 9'(v);
        return m;
    endfunction

    function automatic logic [224:0] ramp();
        logic [224:0] m;
        for (int i = 0; i < 25; i++) m[i*9 +: 9] = 9'(i);
        return m;
    endfunction

    function automatic logic [224:0] ident();
        logic [224:0] m = '0;
        for (int i = 0; i < 5; i++) m[(i*6)*9 +: 9] = 9'd1;
        return m;
    endfunction

    function automatic int ge(input logic [224:0] m, input int r, input int c);
        return int'($signed(m[(r*5+c)*9 +: 9]));
    endfunction

    task automatic model(input logic [2:0] op, input logic [224:0] x, input logic [224:0] y,
                         output logic [224:0] m, output logic ov);
        ov = 1'b0;
        m = '0;
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) begin
                int v;
                v = 0;
                case (op)
                    3'd0: v = ge(x, r, c) + ge(y, r, c);
                    3'd1: v = ge(x, r, c) - ge(y, r, c);
                    3'd2: for (int j = 0; j < 5; j++) v += ge(x, r, j) * ge(y, j, c);
                    3'd3: v = ge(x, c, r);
                    3'd4: v = -ge(x, r, c);
                    default: v = 0;
                endcase
                if (v > 255) begin v = 255; ov = 1'b1; end
                if (v < -256) begin v = -256; ov = 1'b1; end
                m[(r*5+c)*9 +: 9] = v[8:0];
            end
    endtask

    task automatic run(input string tag, input logic [2:0] op, input logic [224:0] x,
                       input logic [224:0] y, input int poke_at, input bit poke_done);
        exp_t e;
        int t0, lat;
        model(op, x, y, e.m, e.ov);
        e.er = op > 3'd4;
        e.lat = op == 3'd2 ? 126 : op > 3'd4 ? 2 : 26;
        sb.push_back(e);
        @(negedge clk);
        operacao = op;
        matriz_A = x;
        matriz_B = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        t0 = cyc;
        start = 1'b0;
        chk({tag, "_busy"}, 225'(busy), 225'(1));
        lat = -1;
        for (int i = 1; i <= 200; i++) begin
            if (i == poke_at) begin
                start = 1'b1;
                operacao = 3'd0;
                matriz_A = ~x;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (done) begin
                lat = cyc - t0;
                break;
            end
        end
        e = sb.pop_front();
        chk({tag, "_latency"}, 225'(lat), 225'(e.lat));
        chk({tag, "_result"}, matriz_resultado, e.m);
        chk({tag, "_overflow"}, 225'(overflow), 225'(e.ov));
        chk({tag, "_erro"}, 225'(erro), 225'(e.er));
        if (poke_done) begin
            start = 1'b1;
            operacao = 3'd0;
        end
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_done_pulse"}, 225'(done), 225'(0));
        chk({tag, "_idle"}, 225'(busy), 225'(0));
        chk({tag, "_hold"}, matriz_resultado, e.m);
    endtask

    initial begin
        bit seen;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_result", matriz_resultado, '0);
        chk("rst_flags", {221'd0, done, busy, overflow, erro}, '0);
        @(negedge clk);
        rst = 1'b0;
        run("add", 3'd0, fill(3), fill(4), 0, 1'b1);
        run("add_sat", 3'd0, fill(200), fill(100), 0, 1'b0);
        run("neg_sat", 3'd4, fill(-256), fill(0), 0, 1'b0);
        run("sub", 3'd1, ramp(), fill(7), 0, 1'b0);
        run("mul_id", 3'd2, ident(), ramp(), 0, 1'b0);
        run("mul_sat", 3'd2, fill(10), fill(10), 0, 1'b0);
        run("transp", 3'd3, ramp(), fill(0), 10, 1'b0);
        run("rsv", 3'd6, ramp(), ramp(), 0, 1'b0);
        @(negedge clk);
        operacao = 3'd2;
        matriz_A = ident();
        matriz_B = ramp();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #1;
        chk("mid_mul_partial", 225'(matriz_resultado != '0), 225'(1));
        rst = 1'b1;
        #1;
        chk("abort_result", matriz_resultado, '0);
        chk("abort_flags", {221'd0, done, busy, overflow, erro}, '0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (150) begin
            @(posedge clk);
            #1;
            seen |= done;
        end
        chk("abort_no_done", 225'(seen), 225'(0));
        run("add_after_rst", 3'd0, ramp(), fill(-5), 0, 1'b0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
